// File: rtl/lcd_write_arbiter_if.sv
// lcd_write_arbiter_if: requester, LCD controller and status signals of lcd_write_arbiter.
// master = requesters/LCD controller side, slave = the arbiter.
interface lcd_write_arbiter_if;
    logic       iREQ0, iREQ1;
    logic [7:0] iDATA0, iDATA1;
    logic       iRS0, iRS1;
    logic       oGNT0, oGNT1;
    logic       oACK0, oACK1;
    logic [7:0] oLCD_DATA;
    logic       oLCD_RS;
    logic       oLCD_Start;
    logic       iLCD_Done;
    logic       oBusy;
    logic       oERR;

    modport master (
        output iREQ0, iREQ1, iDATA0, iDATA1, iRS0, iRS1, iLCD_Done,
        input  oGNT0, oGNT1, oACK0, oACK1, oLCD_DATA, oLCD_RS, oLCD_Start, oBusy, oERR
    );

    modport slave (
        input  iREQ0, iREQ1, iDATA0, iDATA1, iRS0, iRS1, iLCD_Done,
        output oGNT0, oGNT1, oACK0, oACK1, oLCD_DATA, oLCD_RS, oLCD_Start, oBusy, oERR
    );
endinterface

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: round-robin arbiter sharing one LCD_Controller between two byte writers.
// Optional Done watchdog enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_write_arbiter #(
    parameter logic [17:0] DLY_CYCLES = 18'h3FFFE,
    parameter logic [15:0] TMO_CYCLES = 16'hFFFF
) (
    input logic           iCLK,
    input logic           iRST_N,
    lcd_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DELAY, ACK} state_t;

    state_t      state;
    logic [17:0] cnt;
    logic        ptr;
    logic        owner;
    logic        win;
    logic        timeout;

    // ptr holds the last winner; on contention the other requester wins
    assign win = (bus.iREQ0 && bus.iREQ1) ? ~ptr : bus.iREQ1;
    assign bus.oBusy = state != IDLE;

`ifdef LCD_ARB_TIMEOUT_EN
    logic [15:0] wd;
    logic        err;

    assign timeout = wd == TMO_CYCLES - 16'd1;
    assign bus.oERR = err;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wd  <= 16'd0;
            err <= 1'b0;
        end else begin
            err <= state == ISSUE && !bus.iLCD_Done && timeout;
            wd  <= state == ISSUE ? wd + 16'd1 : 16'd0;
        end
    end
`else
    assign timeout = 1'b0;
    assign bus.oERR = 1'b0;
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state          <= IDLE;
            cnt            <= 18'd0;
            ptr            <= 1'b1;
            owner          <= 1'b0;
            bus.oLCD_DATA  <= 8'd0;
            bus.oLCD_RS    <= 1'b0;
            bus.oLCD_Start <= 1'b0;
            bus.oGNT0      <= 1'b0;
            bus.oGNT1      <= 1'b0;
            bus.oACK0      <= 1'b0;
            bus.oACK1      <= 1'b0;
        end else begin
            bus.oGNT0 <= 1'b0;
            bus.oGNT1 <= 1'b0;
            bus.oACK0 <= 1'b0;
            bus.oACK1 <= 1'b0;
            case (state)
                IDLE: if (bus.iREQ0 || bus.iREQ1) begin
                    owner          <= win;
                    ptr            <= win;
                    bus.oLCD_DATA  <= win ? bus.iDATA1 : bus.iDATA0;
                    bus.oLCD_RS    <= win ? bus.iRS1 : bus.iRS0;
                    bus.oLCD_Start <= 1'b1;
                    bus.oGNT0      <= ~win;
                    bus.oGNT1      <= win;
                    state          <= ISSUE;
                end
                ISSUE: if (bus.iLCD_Done || timeout) begin
                    bus.oLCD_Start <= 1'b0;
                    cnt            <= 18'd0;
                    state          <= DELAY;
                end
                DELAY: if (cnt == DLY_CYCLES - 18'd1) begin
                    bus.oACK0 <= ~owner;
                    bus.oACK1 <= owner;
                    state     <= ACK;
                end else begin
                    cnt <= cnt + 18'd1;
                end
                ACK: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: directed and randomized checks of lcd_write_arbiter against a
// transaction-level timing model (DLY_CYCLES=4, TMO_CYCLES=8).
module tb_lcd_write_arbiter;
    localparam int DLY = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_write_arbiter_if bus();

    lcd_write_arbiter #(.DLY_CYCLES(18'd4), .TMO_CYCLES(16'd8)) dut (
        .iCLK(clk),
        .iRST_N(rst_n),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a write is a timeline (grant edge, Done edge, ack edge = Done edge + DLY)
    int         cyc = 0;
    int         t_iss = 0;
    int         t_ack = 0;
    bit         m_act = 0, m_iss = 0, m_own = 0, m_ptr = 1, m_rs = 0;
    bit         m_gnt0 = 0, m_gnt1 = 0, m_ack0 = 0, m_ack1 = 0, m_err = 0;
    logic [7:0] m_data = 8'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_iss = 0; m_own = 0; m_ptr = 1; m_rs = 0; m_data = 8'd0;
            m_gnt0 = 0; m_gnt1 = 0; m_ack0 = 0; m_ack1 = 0; m_err = 0;
        end else begin
            cyc++;
            m_gnt0 = 0; m_gnt1 = 0; m_ack0 = 0; m_ack1 = 0; m_err = 0;
            if (!m_act) begin
                if (bus.iREQ0 || bus.iREQ1) begin
                    if (bus.iREQ0 && bus.iREQ1) m_own = (m_ptr == 0);
                    else m_own = bus.iREQ1;
                    m_ptr  = m_own;
                    m_data = m_own ? bus.iDATA1 : bus.iDATA0;
                    m_rs   = m_own ? bus.iRS1 : bus.iRS0;
                    m_gnt0 = !m_own;
                    m_gnt1 = m_own;
                    m_act  = 1;
                    m_iss  = 1;
                    t_iss  = cyc;
                end
            end else if (m_iss) begin
                if (bus.iLCD_Done) begin
                    m_iss = 0;
                    t_ack = cyc + DLY;
                end
`ifdef LCD_ARB_TIMEOUT_EN
                else if (cyc - t_iss == TMO) begin
                    m_iss = 0;
                    m_err = 1;
                    t_ack = cyc + DLY;
                end
`endif
            end else if (cyc == t_ack) begin
                m_ack0 = !m_own;
                m_ack1 = m_own;
            end else if (cyc == t_ack + 1) begin
                m_act = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1)
            check("cycle",
                  32'({bus.oGNT0, bus.oGNT1, bus.oACK0, bus.oACK1, bus.oLCD_Start, bus.oBusy, bus.oERR, bus.oLCD_RS, bus.oLCD_DATA}),
                  32'({m_gnt0, m_gnt1, m_ack0, m_ack1, m_act && m_iss, m_act, m_err, m_rs, m_data}));
    end

    // Stimulus: requesters and a stand-in LCD controller, all driven on the falling edge
    int tk = 0, sc = 0, dlat = 3, done_tick = 0, p0 = 0, p1 = 0;
    bit noise = 0, rnd = 0;
    int glog[$];

    task automatic tick();
        @(negedge clk);
        tk++;
        if (bus.oGNT0) begin bus.iREQ0 = 0; glog.push_back(0); end
        if (bus.oGNT1) begin bus.iREQ1 = 0; glog.push_back(1); end
        if (bus.oLCD_Start) begin
            sc++;
            bus.iLCD_Done = dlat != 0 && sc == dlat;
            if (bus.iLCD_Done) done_tick = tk;
        end else begin
            sc = 0;
            if (rnd) dlat = int'($urandom_range(5, 1));
            bus.iLCD_Done = noise && $urandom_range(3) == 0;
        end
        if (!bus.iREQ0 && !bus.oGNT0 && int'($urandom_range(99)) < p0) begin
            bus.iREQ0 = 1; bus.iDATA0 = 8'($urandom); bus.iRS0 = 1'($urandom);
        end
        if (!bus.iREQ1 && !bus.oGNT1 && int'($urandom_range(99)) < p1) begin
            bus.iREQ1 = 1; bus.iDATA1 = 8'($urandom); bus.iRS1 = 1'($urandom);
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        bus.iREQ0 = 0; bus.iREQ1 = 0;
        repeat (3) tick();
        check("reset_state",
              32'({bus.oGNT0, bus.oGNT1, bus.oACK0, bus.oACK1, bus.oLCD_Start, bus.oBusy, bus.oERR, bus.oLCD_RS, bus.oLCD_DATA}), 0);
        rst_n = 1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.oBusy || bus.iREQ0 || bus.iREQ1) && n < 200) begin tick(); n++; end
        check("idle", 32'(bus.oBusy), 0);
    endtask

    task automatic wait_gnt(input bit who, input string nm);
        int n = 0;
        while (!(who ? bus.oGNT1 : bus.oGNT0) && n < 40) begin tick(); n++; end
        check(nm, 32'(who ? bus.oGNT1 : bus.oGNT0), 1);
    endtask

    initial begin
        int n, g, e;
        bit held, early, stuck;
        bus.iREQ0 = 0; bus.iREQ1 = 0; bus.iDATA0 = 0; bus.iDATA1 = 0;
        bus.iRS0 = 0; bus.iRS1 = 0; bus.iLCD_Done = 0;

        // contention: both always requesting -> 0,1,0,1
        do_reset();
        p0 = 100; p1 = 100; dlat = 2;
        glog.delete();
        n = 0;
        while (glog.size() < 4 && n < 200) begin tick(); n++; end
        check("rr_count", 32'(glog.size() >= 4), 1);
        if (glog.size() >= 4)
            for (int i = 0; i < 4; i++) check("rr_order", 32'(glog[i]), 32'(i % 2));
        p0 = 0; p1 = 0;
        wait_idle();

        // single write
        do_reset();
        dlat = 3;
        bus.iREQ0 = 1; bus.iDATA0 = 8'h50; bus.iRS0 = 1;
        wait_gnt(0, "wr_gnt0");
        check("wr_data", 32'(bus.oLCD_DATA), 32'h50);
        check("wr_rs", 32'(bus.oLCD_RS), 1);
        n = 0;
        while (bus.oLCD_Start && n < 20) begin n++; tick(); end
        check("start_len", 32'(n), 3);
        while (!bus.oACK0 && tk - done_tick < 20) tick();
        check("ack_lat", 32'(tk - done_tick), 5);
        wait_idle();

        // hold-off of requester 1 during requester 0's write
        bus.iREQ0 = 1; bus.iDATA0 = 8'hA5; bus.iRS0 = 0;
        wait_gnt(0, "ho_gnt0");
        tick();
        bus.iREQ1 = 1; bus.iDATA1 = 8'h3C; bus.iRS1 = 1;
        held = 1; early = 0; n = 0;
        while (!bus.oACK0 && n < 40) begin
            tick(); n++;
            if (bus.oGNT1) early = 1;
            if (bus.oLCD_DATA != 8'hA5) held = 0;
        end
        check("ho_ack0", 32'(bus.oACK0), 1);
        check("ho_no_gnt1", 32'(early), 0);
        check("ho_data_held", 32'(held), 1);
        n = 0;
        while (!bus.oGNT1 && n < 10) begin tick(); n++; end
        check("ho_gnt1_gap", 32'(n), 2);
        check("ho_data1", 32'(bus.oLCD_DATA), 32'h3C);
        wait_idle();

        // reset in the middle of ISSUE
        dlat = 0;
        bus.iREQ0 = 1; bus.iDATA0 = 8'h77; bus.iRS0 = 1;
        wait_gnt(0, "rst_gnt0");
        tick();
        #2 rst_n = 0;
        #1;
        check("rst_start", 32'(bus.oLCD_Start), 0);
        check("rst_busy", 32'(bus.oBusy), 0);
        repeat (3) begin
            tick();
            check("rst_no_ack", 32'({bus.oACK0, bus.oACK1}), 0);
        end
        rst_n = 1;
        dlat = 3;
        bus.iREQ1 = 1; bus.iDATA1 = 8'h9A; bus.iRS1 = 0;
        wait_gnt(1, "post_rst_gnt1");
        check("post_rst_data", 32'(bus.oLCD_DATA), 32'h9A);
        wait_idle();

        // Done never returned
        dlat = 0;
        bus.iREQ0 = 1; bus.iDATA0 = 8'h11;
        wait_gnt(0, "wd_gnt0");
        g = tk;
`ifdef LCD_ARB_TIMEOUT_EN
        while (!bus.oERR && tk - g < 30) tick();
        check("wd_err_lat", 32'(tk - g), 8);
        e = tk;
        while (!bus.oACK0 && tk - e < 30) tick();
        check("wd_ack_lat", 32'(tk - e), 4);
        dlat = 3;
        wait_idle();
`else
        e = 0;
        stuck = 1;
        repeat (20) begin
            tick();
            if (!bus.oBusy || bus.oERR) stuck = 1'b0;
        end
        check("wd_stuck", 32'(stuck + e), 1);
        dlat = 3;
        do_reset();
`endif

        // randomized traffic with spurious Done outside ISSUE
        do_reset();
        p0 = 30; p1 = 30; noise = 1; rnd = 1;
        repeat (3000) tick();
        p0 = 0; p1 = 0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
